ram_bridge_cmd: RTL and testbench

Parametrised host-to-memory command bridge driven by a UART byte stream. It parses single writes, auto-incrementing burst writes and single reads, and drives one memory port. Read data is returned as a byte stream through a ready/valid transmit handshake. Partial frames are aborted by a timeout. It sits between the UART receiver/transmitter and any on-chip RAM used for fast program and asset loading during test.

---
 rtl/ram_bridge_cmd.sv | 211 +++++++++++++++++++++
 tb/tb_ram_bridge_cmd.sv | 353 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_bridge_cmd.sv
// UART byte-stream command bridge: parses 'W' / 'B' / 'R' frames and drives one memory port.
// Read data is returned as 'r' followed by the word, LSB first, over a ready/valid handshake.
module ram_bridge_cmd #(
  parameter int unsigned ADDR_BYTES     = 4,
  parameter int unsigned DATA_WIDTH     = 36,
  parameter int unsigned TIMEOUT_CYCLES = 1_000_000
) (
  input  logic                    clk_in,
  input  logic                    rst_n_in,
  input  logic [7:0]              rx_data_in,
  input  logic                    rx_valid_in,
  output logic [8*ADDR_BYTES-1:0] mem_addr_out,
  output logic [DATA_WIDTH-1:0]   mem_wdata_out,
  output logic                    mem_we_out,
  output logic                    mem_re_out,
  input  logic [DATA_WIDTH-1:0]   mem_rdata_in,
  input  logic                    mem_rvalid_in,
  output logic [7:0]              tx_data_out,
  output logic                    tx_valid_out,
  input  logic                    tx_ready_in,
  output logic                    busy_out,
  output logic                    err_out
);

  localparam int unsigned AW         = 8 * ADDR_BYTES;
  localparam int unsigned DATA_BYTES = (DATA_WIDTH + 7) / 8;
  localparam int unsigned DW8        = 8 * DATA_BYTES;
  localparam int unsigned TW         = $clog2(TIMEOUT_CYCLES + 1);
  localparam int unsigned CW         = 16;

  localparam logic [7:0] CmdWrite = 8'h57;
  localparam logic [7:0] CmdBurst = 8'h42;
  localparam logic [7:0] CmdRead  = 8'h52;
  localparam logic [7:0] RplRead  = 8'h72;

  typedef enum logic [2:0] {StIdle, StAddr, StCount, StData, StRdReq, StRdWait, StTx} state_e;
  typedef enum logic [1:0] {ModeW, ModeB, ModeR} mode_e;

  state_e                r_state, w_state_next;
  mode_e                 r_mode, w_mode_next;
  logic [AW-1:0]         r_addr, w_addr_next, w_addr_shift, w_rx_addr;
  logic [DW8-1:0]        r_word, w_word_next, w_word_shift, w_rx_word;
  logic [DW8-1:0]        r_rbuf, w_rbuf_next;
  logic [DATA_WIDTH-1:0] r_wdata, w_wdata_next;
  logic [8:0]            r_remain, w_remain_next;
  logic [CW-1:0]         r_cnt, w_cnt_next;
  logic [TW-1:0]         r_timer, w_timer_next;
  logic                  r_we, w_we_next, r_re, w_re_next, r_err, w_err_next;
  logic                  r_tx_valid, w_tx_valid_next;
  logic [7:0]            r_tx_data, w_tx_data_next;

  logic w_cmd_ok, w_addr_last, w_data_last, w_tx_last, w_tx_fire, w_run, w_timeout;

  assign w_cmd_ok    = (rx_data_in == CmdWrite) || (rx_data_in == CmdBurst) ||
                       (rx_data_in == CmdRead);
  assign w_addr_last = (r_cnt == CW'(ADDR_BYTES - 1));
  assign w_data_last = (r_cnt == CW'(DATA_BYTES - 1));
  assign w_tx_last   = (r_cnt == CW'(DATA_BYTES));
  assign w_tx_fire   = r_tx_valid && tx_ready_in;
  assign w_run       = (r_state == StAddr) || (r_state == StCount) ||
                       (r_state == StData) || (r_state == StRdWait);
  assign w_timeout   = w_run && !rx_valid_in && (r_timer == TW'(TIMEOUT_CYCLES - 1));

  // Multi-byte fields arrive LSB first: shift each new byte in at the top.
  assign w_rx_addr    = AW'(rx_data_in);
  assign w_rx_word    = DW8'(rx_data_in);
  assign w_addr_shift = (r_addr >> 8) | (w_rx_addr << (AW - 8));
  assign w_word_shift = (r_word >> 8) | (w_rx_word << (DW8 - 8));

  always_ff @(posedge clk_in) begin : p_state_reg
    if (!rst_n_in) r_state <= StIdle;
    else           r_state <= w_state_next;
  end

  always_comb begin : p_next_state
    w_state_next = r_state;
    if (w_timeout) begin
      w_state_next = StIdle;
    end else begin
      case (r_state)
        StIdle:   if (rx_valid_in && w_cmd_ok) w_state_next = StAddr;
        StAddr:   if (rx_valid_in && w_addr_last) begin
          if (r_mode == ModeR)      w_state_next = StRdReq;
          else if (r_mode == ModeB) w_state_next = StCount;
          else                      w_state_next = StData;
        end
        StCount:  if (rx_valid_in) w_state_next = StData;
        StData:   if (rx_valid_in && w_data_last &&
                      ((r_mode != ModeB) || (r_remain == 9'd1))) w_state_next = StIdle;
        StRdReq:  w_state_next = StRdWait;
        StRdWait: if (mem_rvalid_in) w_state_next = StTx;
        StTx:     if (w_tx_fire && w_tx_last) w_state_next = StIdle;
        default:  w_state_next = StIdle;
      endcase
    end
  end

  always_comb begin : p_outputs
    w_mode_next     = r_mode;
    w_addr_next     = r_addr;
    w_word_next     = r_word;
    w_wdata_next    = r_wdata;
    w_rbuf_next     = r_rbuf;
    w_remain_next   = r_remain;
    w_cnt_next      = r_cnt;
    w_we_next       = 1'b0;
    w_re_next       = 1'b0;
    w_err_next      = w_timeout;
    w_tx_valid_next = r_tx_valid;
    w_tx_data_next  = r_tx_data;
    w_timer_next    = (w_run && !rx_valid_in && !w_timeout) ? r_timer + TW'(1) : '0;
    // Burst address advances the cycle after each strobe so the strobe sees the old address.
    if (r_we && (r_mode == ModeB)) w_addr_next = r_addr + AW'(1);
    if (!w_timeout) begin
      case (r_state)
        StIdle: if (rx_valid_in) begin
          if (w_cmd_ok) begin
            w_cnt_next = '0;
            if (rx_data_in == CmdWrite)      w_mode_next = ModeW;
            else if (rx_data_in == CmdBurst) w_mode_next = ModeB;
            else                             w_mode_next = ModeR;
          end else begin
            w_err_next = 1'b1;
          end
        end
        StAddr: if (rx_valid_in) begin
          w_addr_next = w_addr_shift;
          w_cnt_next  = w_addr_last ? '0 : r_cnt + CW'(1);
          w_re_next   = w_addr_last && (r_mode == ModeR);
        end
        StCount: if (rx_valid_in) begin
          w_remain_next = {(rx_data_in == 8'h00), rx_data_in};
        end
        StData: if (rx_valid_in) begin
          w_word_next = w_word_shift;
          w_cnt_next  = w_data_last ? '0 : r_cnt + CW'(1);
          if (w_data_last) begin
            w_we_next     = 1'b1;
            w_wdata_next  = w_word_shift[DATA_WIDTH-1:0];
            w_remain_next = r_remain - 9'd1;
          end
        end
        StRdReq: w_err_next = rx_valid_in;
        StRdWait: begin
          w_err_next = rx_valid_in;
          if (mem_rvalid_in) begin
            w_rbuf_next     = DW8'(mem_rdata_in);
            w_tx_data_next  = RplRead;
            w_tx_valid_next = 1'b1;
            w_cnt_next      = '0;
          end
        end
        StTx: begin
          w_err_next = rx_valid_in;
          if (w_tx_fire) begin
            if (w_tx_last) begin
              w_tx_valid_next = 1'b0;
            end else begin
              w_tx_data_next = r_rbuf[7:0];
              w_rbuf_next    = r_rbuf >> 8;
              w_cnt_next     = r_cnt + CW'(1);
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_in) begin : p_datapath
    if (!rst_n_in) begin
      r_mode     <= ModeW;
      r_addr     <= '0;
      r_word     <= '0;
      r_wdata    <= '0;
      r_rbuf     <= '0;
      r_remain   <= '0;
      r_cnt      <= '0;
      r_timer    <= '0;
      r_we       <= 1'b0;
      r_re       <= 1'b0;
      r_err      <= 1'b0;
      r_tx_valid <= 1'b0;
      r_tx_data  <= '0;
    end else begin
      r_mode     <= w_mode_next;
      r_addr     <= w_addr_next;
      r_word     <= w_word_next;
      r_wdata    <= w_wdata_next;
      r_rbuf     <= w_rbuf_next;
      r_remain   <= w_remain_next;
      r_cnt      <= w_cnt_next;
      r_timer    <= w_timer_next;
      r_we       <= w_we_next;
      r_re       <= w_re_next;
      r_err      <= w_err_next;
      r_tx_valid <= w_tx_valid_next;
      r_tx_data  <= w_tx_data_next;
    end
  end

  assign mem_addr_out  = r_addr;
  assign mem_wdata_out = r_wdata;
  assign mem_we_out    = r_we;
  assign mem_re_out    = r_re;
  assign tx_data_out   = r_tx_data;
  assign tx_valid_out  = r_tx_valid;
  assign busy_out      = (r_state != StIdle);
  assign err_out       = r_err;

endmodule

// File: tb/tb_ram_bridge_cmd.sv
// Scoreboard bench for ram_bridge_cmd: frame tasks push expected writes, reads, reply bytes
// and error pulses; monitor and memory-responder processes pop and compare.
module tb_ram_bridge_cmd;

  localparam int unsigned TMO = 100;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  rx_data = '0;
  logic        rx_valid = 1'b0;
  logic [31:0] mem_addr;
  logic [35:0] mem_wdata;
  logic        mem_we, mem_re;
  logic [35:0] mem_rdata = '0;
  logic        mem_rvalid = 1'b0;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready = 1'b1;
  logic        busy, err;

  ram_bridge_cmd #(
    .ADDR_BYTES    (4),
    .DATA_WIDTH    (36),
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk_in       (clk),
    .rst_n_in     (rst_n),
    .rx_data_in   (rx_data),
    .rx_valid_in  (rx_valid),
    .mem_addr_out (mem_addr),
    .mem_wdata_out(mem_wdata),
    .mem_we_out   (mem_we),
    .mem_re_out   (mem_re),
    .mem_rdata_in (mem_rdata),
    .mem_rvalid_in(mem_rvalid),
    .tx_data_out  (tx_data),
    .tx_valid_out (tx_valid),
    .tx_ready_in  (tx_ready),
    .busy_out     (busy),
    .err_out      (err)
  );

  always #5 clk = ~clk;

  typedef struct { logic [31:0] a; logic [35:0] d; int c; } wr_t;
  typedef struct { logic [31:0] a; int c; } re_t;
  typedef struct { logic [35:0] d; int lat; } rd_t;

  wr_t         exp_wr[$];
  re_t         exp_re[$];
  rd_t         rd_q[$];
  logic [7:0]  exp_tx[$];
  int          exp_err[$];
  logic [35:0] mem_m[logic [31:0]];

  int   cyc = 0, n_checks = 0, n_pass = 0, ready_mode = 2;
  bit   gaps = 1'b0;
  logic prev_re = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
    n_checks++;
    if (act === expv) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, expv, cyc);
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  // Returns the negedge count before the edge that accepts the byte.
  task automatic send_byte(input logic [7:0] b, output int k);
    if (gaps) idle($urandom_range(0, 2));
    rx_data  = b;
    rx_valid = 1'b1;
    @(posedge clk);
    k = cyc;
    #1;
    rx_valid = 1'b0;
  endtask

  task automatic send_addr(input logic [31:0] a, output int k);
    for (int i = 0; i < 4; i++) send_byte(a[8*i +: 8], k);
  endtask

  task automatic send_word(input logic [39:0] w, output int k);
    for (int i = 0; i < 5; i++) send_byte(w[8*i +: 8], k);
  endtask

  function automatic logic [39:0] rand40();
    logic [39:0] w;
    w[31:0]  = $urandom();
    w[39:32] = 8'($urandom());
    return w;
  endfunction

  task automatic do_write(input logic [31:0] a, input logic [39:0] w);
    int k;
    send_byte(8'h57, k);
    send_addr(a, k);
    send_word(w, k);
    exp_wr.push_back('{a, w[35:0], k + 1});
    mem_m[a] = w[35:0];
  endtask

  task automatic do_burst(input logic [31:0] a, input logic [7:0] n8, input bit seq);
    int k, n;
    logic [39:0] w;
    logic [31:0] wa;
    n = (n8 == 8'd0) ? 256 : int'(n8);
    send_byte(8'h42, k);
    send_addr(a, k);
    send_byte(n8, k);
    for (int i = 0; i < n; i++) begin
      w  = seq ? 40'(i + 1) : rand40();
      wa = a + 32'(i);
      send_word(w, k);
      exp_wr.push_back('{wa, w[35:0], k + 1});
      mem_m[wa] = w[35:0];
    end
  endtask

  task automatic do_read(input logic [31:0] a, input logic [35:0] d, input int lat);
    int k;
    logic [39:0] z;
    rd_q.push_back('{d, lat});
    send_byte(8'h52, k);
    send_addr(a, k);
    exp_re.push_back('{a, k + 1});
    z = {4'b0, d};
    exp_tx.push_back(8'h72);
    for (int i = 0; i < 5; i++) exp_tx.push_back(z[8*i +: 8]);
  endtask

  task automatic wait_idle(input string name);
    int t = 0;
    while ((busy || exp_tx.size() != 0 || exp_wr.size() != 0) && t < 4000) begin
      @(posedge clk); #1; t++;
    end
    chk(name, 64'(busy), 64'd0);
  endtask

  task automatic check_zero_outputs(input string tag);
    chk({tag, "_addr"}, 64'(mem_addr), 64'd0);
    chk({tag, "_wdata"}, 64'(mem_wdata), 64'd0);
    chk({tag, "_we"}, 64'(mem_we), 64'd0);
    chk({tag, "_re"}, 64'(mem_re), 64'd0);
    chk({tag, "_txdata"}, 64'(tx_data), 64'd0);
    chk({tag, "_txvalid"}, 64'(tx_valid), 64'd0);
    chk({tag, "_busy"}, 64'(busy), 64'd0);
    chk({tag, "_err"}, 64'(err), 64'd0);
  endtask

  // Monitor: cycle count advances on every negedge, so an event at edge k shows as cyc == k + 1.
  initial begin : monitor
    wr_t w;
    logic [7:0] b;
    int ec;
    forever begin
      @(negedge clk);
      cyc++;
      if (rst_n) begin
        if (mem_we) begin
          chk("wr_expected", 64'(exp_wr.size() != 0), 64'd1);
          if (exp_wr.size() != 0) begin
            w = exp_wr.pop_front();
            chk("wr_addr", 64'(mem_addr), 64'(w.a));
            chk("wr_data", 64'(mem_wdata), 64'(w.d));
            chk("wr_cycle", 64'(cyc), 64'(w.c));
          end
        end
        if (mem_re) chk("re_single", 64'(prev_re), 64'd0);
        if (err) begin
          chk("err_expected", 64'(exp_err.size() != 0), 64'd1);
          if (exp_err.size() != 0) begin
            ec = exp_err.pop_front();
            chk("err_cycle", 64'(cyc), 64'(ec));
          end
        end
        if (tx_valid && tx_ready) begin
          chk("tx_expected", 64'(exp_tx.size() != 0), 64'd1);
          if (exp_tx.size() != 0) begin
            b = exp_tx.pop_front();
            chk("tx_byte", 64'(tx_data), 64'(b));
          end
        end
      end
      prev_re = mem_re;
    end
  end

  initial begin : responder
    re_t e;
    rd_t r;
    forever begin
      @(negedge clk);
      if (rst_n && mem_re) begin
        chk("re_expected", 64'(exp_re.size() != 0 && rd_q.size() != 0), 64'd1);
        if (exp_re.size() != 0 && rd_q.size() != 0) begin
          e = exp_re.pop_front();
          r = rd_q.pop_front();
          chk("re_addr", 64'(mem_addr), 64'(e.a));
          chk("re_cycle", 64'(cyc), 64'(e.c));
          repeat (r.lat) @(posedge clk);
          #1;
          mem_rdata  = r.d;
          mem_rvalid = 1'b1;
          @(posedge clk);
          #1;
          mem_rvalid = 1'b0;
          chk("rd_addr_held", 64'(mem_addr), 64'(e.a));
          @(negedge clk);
          chk("reply_valid", 64'(tx_valid), 64'd1);
          chk("reply_tag", 64'(tx_data), 64'h72);
        end
      end
    end
  end

  initial begin : ready_drv
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        0:       tx_ready = ~tx_ready;
        1:       tx_ready = 1'($urandom_range(0, 1));
        3:       tx_ready = 1'b0;
        default: tx_ready = 1'b1;
      endcase
    end
  end

  initial begin : watchdog
    #800000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", n_pass, n_checks);
    $fatal(1);
  end

  initial begin : main
    int k, t;
    logic [31:0] a;
    repeat (3) @(posedge clk);
    #1;
    check_zero_outputs("reset");
    rst_n = 1'b1;
    idle(2);

    // Single write; top nibble of the last byte must be dropped.
    do_write(32'h1234_5678, 40'hF7_89AB_CDEF);
    wait_idle("w_idle");

    // Burst of two sequential words.
    do_burst(32'h10, 8'd2, 1'b1);
    wait_idle("b_idle");

    // Read with 3-cycle memory latency and a toggling transmitter.
    ready_mode = 0;
    do_read(32'h100, 36'hABCDE1234, 3);
    wait_idle("r_idle");
    ready_mode = 2;

    // Stray read-valid while idle must not produce a reply.
    mem_rdata  = 36'h123456789;
    mem_rvalid = 1'b1;
    idle(1);
    mem_rvalid = 1'b0;
    idle(3);
    chk("stray_rvalid_txvalid", 64'(tx_valid), 64'd0);

    // Timeout after a partial frame, then a normal frame.
    send_byte(8'h57, k);
    chk("busy_mid_frame", 64'(busy), 64'd1);
    send_byte(8'h00, k);
    send_byte(8'h01, k);
    exp_err.push_back(k + 1 + int'(TMO));
    idle(TMO + 5);
    chk("timeout_idle", 64'(busy), 64'd0);
    do_write(32'hCAFE_0001, rand40());
    wait_idle("after_timeout_idle");

    // Unknown command byte.
    send_byte(8'h58, k);
    exp_err.push_back(k + 1);
    idle(2);
    chk("bad_cmd_idle", 64'(busy), 64'd0);

    // Byte arriving while a reply is stalled is dropped with an error.
    ready_mode = 3;
    do_read(32'hDEAD_0000, 36'h0_5555_AAAA, 1);
    t = 0;
    while (!tx_valid && t < 50) begin @(posedge clk); #1; t++; end
    chk("tx_start", 64'(tx_valid), 64'd1);
    send_byte(8'h57, k);
    exp_err.push_back(k + 1);
    idle(3);
    ready_mode = 2;
    wait_idle("drop_idle");

    // Address wrap in a burst.
    do_burst(32'hFFFF_FFFF, 8'd2, 1'b0);
    wait_idle("wrap_idle");

    // Count byte 0 means 256 words, bytes back to back.
    do_burst(32'h0000_4000, 8'd0, 1'b0);
    wait_idle("b256_idle");

    // Randomized frames with random gaps, latencies and ready pattern.
    ready_mode = 1;
    for (int i = 0; i < 24; i++) begin
      gaps = 1'($urandom_range(0, 1));
      a = (i % 3 == 0) ? 32'h0000_4000 + 32'($urandom_range(0, 7)) : $urandom();
      case ($urandom_range(0, 2))
        0: do_write(a, rand40());
        1: do_burst(a, 8'($urandom_range(1, 4)), 1'b0);
        default: do_read(a, mem_m.exists(a) ? mem_m[a] : 36'(rand40()),
                         int'($urandom_range(1, 4)));
      endcase
      wait_idle("rand_idle");
    end
    gaps = 1'b0;
    ready_mode = 2;

    // Reset in the middle of a burst: completed words only, then silence.
    do_burst(32'h0000_0200, 8'd2, 1'b0);
    wait_idle("pre_reset_idle");
    send_byte(8'h42, k);
    send_addr(32'h0000_0300, k);
    send_byte(8'd4, k);
    send_word(40'h11_2233_4455, k);
    exp_wr.push_back('{32'h300, 36'h1_2233_4455, k + 1});
    send_byte(8'hAA, k);
    send_byte(8'hBB, k);
    idle(2);
    rst_n = 1'b0;
    idle(2);
    check_zero_outputs("midreset");
    rst_n = 1'b1;
    idle(10);
    chk("midreset_busy", 64'(busy), 64'd0);

    t = 0;
    while ((exp_wr.size() + exp_re.size() + exp_tx.size() + exp_err.size() != 0) && t < 2000) begin
      @(posedge clk); #1; t++;
    end
    chk("left_wr", 64'(exp_wr.size()), 64'd0);
    chk("left_re", 64'(exp_re.size()), 64'd0);
    chk("left_tx", 64'(exp_tx.size()), 64'd0);
    chk("left_err", 64'(exp_err.size()), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
